// File: rtl/color_sense_stabilizer.sv
// Settle-then-filter front end for the cube colour sensors; pulses color_sensor_stable once per move.
// Optional build macro COLOR_TIMEOUT_VOTE_EN: majority-vote fallback on timeout instead of last sample.
module color_sense_stabilizer #(
  parameter int unsigned SETTLE_CYCLES  = 500000,
  parameter int unsigned MATCH_COUNT    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       motors_done,
  input  logic       raw_valid,
  input  logic [2:0] edge_raw,
  input  logic [2:0] corner_raw,
  output logic [2:0] edge_color_sensor,
  output logic [2:0] corner_color_sensor,
  output logic       color_sensor_stable,
  output logic       sense_error
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} state_t;

  state_t         state;
  logic [SW-1:0]  settle_cnt;
  logic [TW-1:0]  timeout_cnt;
  logic [MW-1:0]  edge_match, corner_match, edge_match_nxt, corner_match_nxt;
  logic [2:0]     edge_last, corner_last, edge_last_nxt, corner_last_nxt;
  logic [2:0]     edge_fallback, corner_fallback;
  logic           edge_locked, corner_locked, timed_out;

  // One channel's filter step: returns {match_count, last_sample} after this cycle's sample.
  function automatic logic [MW+2:0] filt(input logic [MW-1:0] m, input logic [2:0] last,
                                          input logic [2:0] raw, input logic v, input logic locked);
    if (!v || locked)
      return {m, last};
    if (raw >= 3'd6)
      return {MW'(0), last};
    if (raw == last)
      return {(m == MW'(MATCH_COUNT)) ? m : m + MW'(1), last};
    return {MW'(1), raw};
  endfunction

  assign edge_locked   = (edge_match == MW'(MATCH_COUNT));
  assign corner_locked = (corner_match == MW'(MATCH_COUNT));
  assign timed_out     = (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

  assign {edge_match_nxt, edge_last_nxt}     = filt(edge_match, edge_last, edge_raw, raw_valid, edge_locked);
  assign {corner_match_nxt, corner_last_nxt} = filt(corner_match, corner_last, corner_raw, raw_valid, corner_locked);

`ifdef COLOR_TIMEOUT_VOTE_EN
  logic [5:0][7:0] edge_hits, corner_hits, edge_hits_nxt, corner_hits_nxt;

  // Highest hit count wins; strict compare keeps the lowest code on ties and 0 when empty.
  function automatic logic [2:0] vote(input logic [5:0][7:0] h);
    logic [2:0] best;
    best = 3'd0;
    for (int i = 1; i < 6; i++)
      if (h[i] > h[best]) best = 3'(i);
    return best;
  endfunction

  always_comb begin
    edge_hits_nxt   = edge_hits;
    corner_hits_nxt = corner_hits;
    for (int i = 0; i < 6; i++) begin
      if (raw_valid && !edge_locked && edge_raw == 3'(i) && edge_hits[i] != 8'hFF)
        edge_hits_nxt[i] = edge_hits[i] + 8'd1;
      if (raw_valid && !corner_locked && corner_raw == 3'(i) && corner_hits[i] != 8'hFF)
        corner_hits_nxt[i] = corner_hits[i] + 8'd1;
    end
  end

  assign edge_fallback   = vote(edge_hits_nxt);
  assign corner_fallback = vote(corner_hits_nxt);

  always_ff @(posedge clock) begin
    if (reset || (state == SETTLE)) begin
      edge_hits   <= '0;
      corner_hits <= '0;
    end else if (state == SAMPLE) begin
      edge_hits   <= edge_hits_nxt;
      corner_hits <= corner_hits_nxt;
    end
  end
`else
  assign edge_fallback   = edge_last_nxt;
  assign corner_fallback = corner_last_nxt;
`endif

  // Sequencer: IDLE -> SETTLE -> SAMPLE -> REPORT (one-cycle pulse) -> IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      settle_cnt          <= '0;
      timeout_cnt         <= '0;
      edge_match          <= '0;
      corner_match        <= '0;
      edge_last           <= '0;
      corner_last         <= '0;
      edge_color_sensor   <= '0;
      corner_color_sensor <= '0;
      color_sensor_stable <= 1'b0;
      sense_error         <= 1'b0;
    end else begin
      color_sensor_stable <= 1'b0;
      case (state)
        IDLE: begin
          if (motors_done) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (motors_done) begin
            settle_cnt <= '0;
          end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            state        <= SAMPLE;
            timeout_cnt  <= '0;
            edge_match   <= '0;
            corner_match <= '0;
            edge_last    <= '0;
            corner_last  <= '0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        SAMPLE: begin
          if (motors_done) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end else if (edge_locked && corner_locked) begin
            state               <= REPORT;
            color_sensor_stable <= 1'b1;
            edge_color_sensor   <= edge_last;
            corner_color_sensor <= corner_last;
          end else if (timed_out) begin
            state               <= REPORT;
            color_sensor_stable <= 1'b1;
            sense_error         <= 1'b1;
            edge_color_sensor   <= edge_locked ? edge_last : edge_fallback;
            corner_color_sensor <= corner_locked ? corner_last : corner_fallback;
          end else begin
            timeout_cnt  <= timeout_cnt + TW'(1);
            edge_match   <= edge_match_nxt;
            corner_match <= corner_match_nxt;
            edge_last    <= edge_last_nxt;
            corner_last  <= corner_last_nxt;
          end
        end
        REPORT:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_color_sense_stabilizer.sv
// Scoreboard bench for color_sense_stabilizer: directed scenarios plus randomized reads.
module tb_color_sense_stabilizer;
  localparam int unsigned S = 4;
  localparam int unsigned M = 3;
  localparam int unsigned T = 40;

  typedef int iq_t[$];
  typedef struct {int cyc; int e; int c; int err;} exp_t;

  logic       clock = 1'b0;
  logic       reset, motors_done, raw_valid;
  logic [2:0] edge_raw, corner_raw;
  logic [2:0] edge_color_sensor, corner_color_sensor;
  logic       color_sensor_stable, sense_error;

  color_sense_stabilizer #(.SETTLE_CYCLES(S), .MATCH_COUNT(M), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .motors_done(motors_done), .raw_valid(raw_valid),
    .edge_raw(edge_raw), .corner_raw(corner_raw),
    .edge_color_sensor(edge_color_sensor), .corner_color_sensor(corner_color_sensor),
    .color_sensor_stable(color_sensor_stable), .sense_error(sense_error)
  );

  always #5 clock = ~clock;

  int   total = 0, bad = 0, cyc = 0, last_pulse_cyc = -1;
  exp_t sbq[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model: tracks edges since the last accepted motors_done and the sample history.
  bit  m_active = 0, m_rep = 0;
  int  k = 0, m_e = 0, m_c = 0, m_err = 0;
  iq_t eh, ch;

  function automatic int run_len(input iq_t q);
    int n = 0;
    if (q.size() == 0 || q[q.size()-1] < 0) return 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != q[q.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  function automatic int fallback(input iq_t q);
`ifdef COLOR_TIMEOUT_VOTE_EN
    int cnt[6];
    int best = 0;
    for (int i = 0; i < 6; i++) cnt[i] = 0;
    foreach (q[i]) if (q[i] >= 0) cnt[q[i]]++;
    for (int i = 1; i < 6; i++) if (cnt[i] > cnt[best]) best = i;
    return best;
`else
    for (int i = q.size() - 1; i >= 0; i--) if (q[i] >= 0) return q[i];
    return 0;
`endif
  endfunction

  task automatic model_step();
    bit le, lc;
    if (reset) begin
      m_active = 0; m_rep = 0; m_e = 0; m_c = 0; m_err = 0;
      eh.delete(); ch.delete();
      return;
    end
    if (m_rep) begin
      m_rep = 0; m_active = 0;
      return;
    end
    if (!m_active) begin
      if (motors_done) begin m_active = 1; k = 0; end
      return;
    end
    k++;
    if (motors_done) begin k = 0; return; end
    if (k <= int'(S)) begin
      if (k == int'(S)) begin eh.delete(); ch.delete(); end
      return;
    end
    le = run_len(eh) >= int'(M);
    lc = run_len(ch) >= int'(M);
    if (le && lc) begin
      m_e = eh[eh.size()-1]; m_c = ch[ch.size()-1];
      m_rep = 1;
      sbq.push_back('{cyc + 1, m_e, m_c, m_err});
      return;
    end
    if (raw_valid && !le) eh.push_back(edge_raw < 3'd6 ? int'(edge_raw) : -1);
    if (raw_valid && !lc) ch.push_back(corner_raw < 3'd6 ? int'(corner_raw) : -1);
    if (k == int'(S + T)) begin
      m_e = le ? eh[eh.size()-1] : fallback(eh);
      m_c = lc ? ch[ch.size()-1] : fallback(ch);
      m_err = 1;
      m_rep = 1;
      sbq.push_back('{cyc + 1, m_e, m_c, m_err});
    end
  endtask

  // Monitor: every stable pulse must match the oldest predicted report.
  always @(negedge clock) begin
    exp_t x;
    if (color_sensor_stable) begin
      last_pulse_cyc = cyc;
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        x = sbq.pop_front();
        chk("pulse_cycle", cyc, x.cyc);
        chk("edge_color", int'(edge_color_sensor), x.e);
        chk("corner_color", int'(corner_color_sensor), x.c);
        chk("sense_error", int'(sense_error), x.err);
      end
    end
  end

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_held(input string nm);
    chk({nm, "_edge"}, int'(edge_color_sensor), m_e);
    chk({nm, "_corner"}, int'(corner_color_sensor), m_c);
    chk({nm, "_err"}, int'(sense_error), m_err);
  endtask

  task automatic drain(input string nm);
    motors_done = 0; raw_valid = 0;
    repeat (2) tick();
    for (int i = 0; i < 120 && (sbq.size() != 0 || m_active || m_rep); i++) tick();
    repeat (2) tick();
    chk({nm, "_pending_reports"}, sbq.size(), 0);
  endtask

  // motors_done, S settle cycles without samples, then n samples from the given sequences.
  task automatic scenario(input iq_t es, input iq_t cs, input int n);
    motors_done = 1; tick(); motors_done = 0;
    raw_valid = 0;
    repeat (S) tick();
    for (int j = 0; j < n; j++) begin
      raw_valid  = 1;
      edge_raw   = 3'(es[j < es.size() ? j : es.size() - 1]);
      corner_raw = 3'(cs[j < cs.size() ? j : cs.size() - 1]);
      tick();
    end
    raw_valid = 0;
  endtask

  initial begin
    int  md_cyc;
    iq_t alt;
    reset = 1; motors_done = 0; raw_valid = 0; edge_raw = 0; corner_raw = 0;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("reset_edge", int'(edge_color_sensor), 0);
    chk("reset_corner", int'(corner_color_sensor), 0);
    chk("reset_stable", int'(color_sensor_stable), 0);
    chk("reset_err", int'(sense_error), 0);

    // Clean read with exact latency
    md_cyc = cyc + 1;
    scenario('{2}, '{5}, 12);
    drain("clean");
    chk("clean_latency", last_pulse_cyc - md_cyc, int'(S + M + 1));
    chk("clean_edge_value", int'(edge_color_sensor), 2);
    chk("clean_corner_value", int'(corner_color_sensor), 5);
    chk("clean_err_value", int'(sense_error), 0);

    scenario('{1, 1, 3, 3, 3}, '{4}, 8);
    drain("flicker");
    chk("flicker_edge_value", int'(edge_color_sensor), 3);

    md_cyc = cyc + 1;
    scenario('{0, 0, 7, 0, 0, 0}, '{1}, 8);
    drain("invalid");
    chk("invalid_latency", last_pulse_cyc - md_cyc, int'(S) + 6 + 1);

    alt.delete();
    for (int j = 0; j < 50; j++) alt.push_back((j % 2 == 0) ? 1 : 4);
    scenario(alt, '{4}, 45);
    drain("timeout");
    chk("timeout_err_value", int'(sense_error), 1);
`ifdef COLOR_TIMEOUT_VOTE_EN
    chk("timeout_edge_value", int'(edge_color_sensor), 1);
`else
    chk("timeout_edge_value", int'(edge_color_sensor), 4);
`endif
    chk("timeout_corner_value", int'(corner_color_sensor), 4);

    scenario('{0}, '{3}, 8);
    drain("sticky");
    chk("sticky_err_value", int'(sense_error), 1);

    // Restart two cycles into SAMPLE
    scenario('{5}, '{5}, 2);
    md_cyc = cyc + 1;
    scenario('{3}, '{2}, 10);
    drain("restart");
    chk("restart_latency", last_pulse_cyc - md_cyc, int'(S + M + 1));

    // Reset mid-SETTLE, then samples without motors_done
    motors_done = 1; tick(); motors_done = 0;
    repeat (2) tick();
    reset = 1; tick(); reset = 0;
    for (int j = 0; j < 50; j++) begin
      raw_valid = 1; edge_raw = 3'd2; corner_raw = 3'd2; tick();
    end
    drain("no_md");
    check_held("after_reset");
    chk("after_reset_zero_edge", int'(edge_color_sensor), 0);

    // Randomized reads with noise, gaps and occasional restarts
    for (int it = 0; it < 40; it++) begin
      int te, tc, noise;
      te = $urandom_range(0, 5); tc = $urandom_range(0, 5);
      noise = $urandom_range(0, 3);
      motors_done = 1; tick(); motors_done = 0;
      for (int j = 0; j < 60; j++) begin
        motors_done = ($urandom_range(0, 59) == 0);
        raw_valid   = ($urandom_range(0, 3) != 0);
        edge_raw    = ($urandom_range(0, 3) < noise) ? 3'($urandom_range(0, 7)) : 3'(te);
        corner_raw  = ($urandom_range(0, 3) < noise) ? 3'($urandom_range(0, 7)) : 3'(tc);
        tick();
      end
      drain("random");
      check_held("random_held");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/color_sense_stabilizer.md
Name: color_sense_stabilizer

Overview:
- Sits directly upstream of the cube-state scanner FSM.
- After each motor move completes, it waits for the cube to settle, then filters the raw edge and corner colour-sensor codes until each is steady.
- It then presents both colours and fires a one-cycle `color_sensor_stable` pulse, which the scanner uses to leave its wait state and latch the observed sticker.
- Guarantees the scanner never sees a stale or still-flickering reading, and never hangs on a bad sensor.

Parameters:
- SETTLE_CYCLES, 500000: clock cycles to wait after `motors_done` before sampling (10 ms at 50 MHz).
- MATCH_COUNT, 16: consecutive identical valid samples required per sensor.
- TIMEOUT_CYCLES, 2000000: maximum cycles spent in SAMPLE before forced report.

Ports:
- clock, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- motors_done, in, 1: one-cycle pulse from the motor sequencer when a move has finished.
- raw_valid, in, 1: strobe; the raw codes below are a fresh sample this cycle.
- edge_raw, in, 3: raw edge-sensor colour code (0=W, 1=O, 2=G, 3=Red, 4=Blue, 5=Y; 6 and 7 are invalid).
- corner_raw, in, 3: raw corner-sensor colour code, same encoding.
- edge_color_sensor, out, 3: filtered edge colour, held between reports.
- corner_color_sensor, out, 3: filtered corner colour, held between reports.
- color_sensor_stable, out, 1: one-cycle pulse; both colour outputs are valid this cycle and onward.
- sense_error, out, 1: sticky; set when any report was forced by timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-operation aborts immediately to IDLE with no pulse.
- Counter widths: `$clog2(param+1)`. Counters saturate and never wrap.
- IDLE:
  - `motors_done` → SETTLE, settle counter cleared.
  - `raw_valid` is ignored.
- SETTLE:
  - Count every clock.
  - When count reaches SETTLE_CYCLES-1 → SAMPLE; clear match counters, last-sample registers and timeout counter.
  - `motors_done` again restarts the settle count at 0.
- SAMPLE:
  - Timeout counter increments every clock.
  - Edge and corner channels are filtered independently, per `raw_valid` sample:
    - Invalid code (6 or 7): that channel's match count resets to 0; last-sample register unchanged.
    - Valid code equal to last sample: match count increments, saturating at MATCH_COUNT.
    - Valid code differing from last sample: last sample is updated and match count becomes 1.
  - A channel is locked when its match count equals MATCH_COUNT. Once locked, its value is frozen for the rest of this SAMPLE.
  - Both channels locked → REPORT, with the locked values written to the outputs.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with either channel unlocked → REPORT with fallback values (see Optional Feature) and `sense_error` set.
  - Both-locked and timeout in the same cycle: the locked result wins and `sense_error` is not set.
  - `motors_done` in SAMPLE → back to SETTLE, count 0, no report.
- REPORT:
  - `color_sensor_stable` = 1 for exactly this cycle, with the colour outputs already updated in the same cycle.
  - Unconditionally → IDLE.
  - `motors_done` in REPORT is ignored.
- Latency, no noise, `raw_valid` every cycle: `motors_done` to pulse = SETTLE_CYCLES + MATCH_COUNT + 1 cycles.
- Stable pulse is never asserted two consecutive cycles and never without a preceding `motors_done`.
- `sense_error` clears only on reset.

Optional Feature:
- Macro: COLOR_TIMEOUT_VOTE_EN.
- Defined:
  - Each channel keeps six per-colour hit counters over all valid samples in the current SAMPLE visit, saturating at 255.
  - On timeout, an unlocked channel outputs the colour with the highest count, lowest code on ties.
  - A channel with no valid samples outputs 0.
- Undefined:
  - An unlocked channel outputs its last valid sample, or 0 if there was none.
  - No hit counters are built.
- Locked channels behave identically in both builds.

Test Plan:
All scenarios use SETTLE_CYCLES=4, MATCH_COUNT=3, TIMEOUT_CYCLES=40.
- Clean read: `motors_done` pulse, then `raw_valid`=1 every cycle with edge=2, corner=5 → stable pulse exactly 8 cycles after `motors_done`, outputs 2/5, `sense_error`=0.
- Flicker: edge sequence 1,1,3,3,3 with corner=4 constant → no pulse until the third consecutive 3; edge output is 3.
- Invalid code: edge 0,0,7,0,0,0 → 7 resets the count; lock only on the third 0 after the 7.
- Timeout: edge alternating 1,4,1,4,... → pulse at timeout, `sense_error`=1 and stays 1 after the next clean read. Edge output is 4 without the macro, and 1 with COLOR_TIMEOUT_VOTE_EN (tie broken to lowest code).
- Restart: second `motors_done` 2 cycles into SAMPLE → no pulse; next pulse arrives a full settle plus match time after the second `motors_done`.
- Reset mid-SETTLE, and `raw_valid` with no `motors_done` → no pulse, all outputs 0.
